morse_transmitter: RTL

MORSE_TRANSMITTER -- requirements
Module: morse_transmitter

---
 rtl/morse_pkg.sv | 21 ++
 rtl/morse_encode_lut.sv | 75 +++++++
 rtl/morse_transmitter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse transmitter.
// State encoding, ASCII anchors and code field widths.
package morse_pkg;

  localparam int CODE_W = 5;
  localparam int LEN_W  = 3;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_UA    = 8'h41;
  localparam logic [7:0] ASCII_LA    = 8'h61;
  localparam logic [7:0] ASCII_0     = 8'h30;

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    SYM_GAP,
    CHAR_GAP,
    WORD_GAP
  } state_t;

endpackage

// File: rtl/morse_encode_lut.sv
// ASCII to Morse code lookup, purely combinational.
// Code: first symbol in bit 4, 1 = dash, 0 = dot.
module morse_encode_lut
  import morse_pkg::*;
(
  input  logic [7:0]        ch,
  output logic [CODE_W-1:0] code,
  output logic [LEN_W-1:0]  len,
  output logic              supported
);

  logic [7:0] up;
  logic [7:0] off;

  // fold lower case, then index letters and digits
  always_comb begin
    code      = '0;
    len       = '0;
    supported = 1'b0;
    up        = ch;
    off       = '0;
    if (ch >= ASCII_LA && ch <= ASCII_LA + 8'd25)
      up = ch - 8'h20;
    if (up >= ASCII_UA && up <= ASCII_UA + 8'd25) begin
      supported = 1'b1;
      off = up - ASCII_UA;
      case (off)
        8'd0:  {code, len} = {5'b01000, 3'd2};
        8'd1:  {code, len} = {5'b10000, 3'd4};
        8'd2:  {code, len} = {5'b10100, 3'd4};
        8'd3:  {code, len} = {5'b10000, 3'd3};
        8'd4:  {code, len} = {5'b00000, 3'd1};
        8'd5:  {code, len} = {5'b00100, 3'd4};
        8'd6:  {code, len} = {5'b11000, 3'd3};
        8'd7:  {code, len} = {5'b00000, 3'd4};
        8'd8:  {code, len} = {5'b00000, 3'd2};
        8'd9:  {code, len} = {5'b01110, 3'd4};
        8'd10: {code, len} = {5'b10100, 3'd3};
        8'd11: {code, len} = {5'b01000, 3'd4};
        8'd12: {code, len} = {5'b11000, 3'd2};
        8'd13: {code, len} = {5'b10000, 3'd2};
        8'd14: {code, len} = {5'b11100, 3'd3};
        8'd15: {code, len} = {5'b01100, 3'd4};
        8'd16: {code, len} = {5'b11010, 3'd4};
        8'd17: {code, len} = {5'b01000, 3'd3};
        8'd18: {code, len} = {5'b00000, 3'd3};
        8'd19: {code, len} = {5'b10000, 3'd1};
        8'd20: {code, len} = {5'b00100, 3'd3};
        8'd21: {code, len} = {5'b00010, 3'd4};
        8'd22: {code, len} = {5'b01100, 3'd3};
        8'd23: {code, len} = {5'b10010, 3'd4};
        8'd24: {code, len} = {5'b10110, 3'd4};
        8'd25: {code, len} = {5'b11000, 3'd4};
        default: {code, len} = '0;
      endcase
    end else if (ch >= ASCII_0 && ch <= ASCII_0 + 8'd9) begin
      supported = 1'b1;
      off = ch - ASCII_0;
      case (off)
        8'd0: {code, len} = {5'b11111, 3'd5};
        8'd1: {code, len} = {5'b01111, 3'd5};
        8'd2: {code, len} = {5'b00111, 3'd5};
        8'd3: {code, len} = {5'b00011, 3'd5};
        8'd4: {code, len} = {5'b00001, 3'd5};
        8'd5: {code, len} = {5'b00000, 3'd5};
        8'd6: {code, len} = {5'b10000, 3'd5};
        8'd7: {code, len} = {5'b11000, 3'd5};
        8'd8: {code, len} = {5'b11100, 3'd5};
        8'd9: {code, len} = {5'b11110, 3'd5};
        default: {code, len} = '0;
      endcase
    end
  end

endmodule

// File: rtl/morse_transmitter.sv
// Morse keyer: accepts ASCII, keys dots/dashes and gaps.
// The IDLE/done cycle is the last cycle of each trailing gap.
module morse_transmitter
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] char_data,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       key_out,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CW = $clog2(UNIT_CYCLES + 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(UNIT_CYCLES - 1);
  // trailing gaps start one tick in; the IDLE cycle finishes them
  localparam logic [CW-1:0] PRE_CYC =
    (UNIT_CYCLES == 1) ? '0 : CW'(1);
  localparam logic [1:0] PRE_UNIT =
    (UNIT_CYCLES == 1) ? 2'd1 : 2'd0;

  state_t state, state_n;
  logic [CW-1:0]     cyc, cyc_n;
  logic [1:0]        unit, unit_n, unit_last;
  logic [CODE_W-1:0] code_q, code_n, lut_code;
  logic [LEN_W-1:0]  len_q, len_n, lut_len;
  logic              lut_ok;
  logic              key_n, done_n, err_n;
  logic              tick_end, st_end;

  morse_encode_lut u_lut (
    .ch        (char_data),
    .code      (lut_code),
    .len       (lut_len),
    .supported (lut_ok)
  );

  assign char_ready = (state == IDLE);
  assign busy       = (state != IDLE);

  // next state, counters and registered-output values
  always_comb begin
    state_n   = state;
    cyc_n     = cyc;
    unit_n    = unit;
    code_n    = code_q;
    len_n     = len_q;
    err_n     = 1'b0;
    done_n    = 1'b0;
    unit_last = 2'd0;
    unique case (state)
      MARK:     unit_last = code_q[CODE_W-1] ? 2'd2 : 2'd0;
      CHAR_GAP: unit_last = 2'd2;
      WORD_GAP: unit_last = 2'd3;
      default:  unit_last = 2'd0;
    endcase
    tick_end = (cyc == CYC_LAST);
    st_end   = tick_end && (unit == unit_last);
    if (state != IDLE) begin
      if (tick_end) begin
        cyc_n  = '0;
        unit_n = unit + 2'd1;
      end else begin
        cyc_n = cyc + CW'(1);
      end
    end
    unique case (state)
      IDLE: begin
        if (char_valid) begin
          if (lut_ok) begin
            state_n = MARK;
            code_n  = lut_code;
            len_n   = lut_len;
            cyc_n   = '0;
            unit_n  = 2'd0;
          end else if (char_data == ASCII_SPACE) begin
            state_n = WORD_GAP;
            cyc_n   = PRE_CYC;
            unit_n  = PRE_UNIT;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      MARK: begin
        if (st_end) begin
          code_n = code_q << 1;
          len_n  = len_q - LEN_W'(1);
          cyc_n  = '0;
          unit_n = 2'd0;
          if (len_q > LEN_W'(1)) begin
            state_n = SYM_GAP;
          end else begin
            state_n = CHAR_GAP;
            cyc_n   = PRE_CYC;
            unit_n  = PRE_UNIT;
          end
        end
      end
      SYM_GAP: begin
        if (st_end) begin
          state_n = MARK;
          cyc_n   = '0;
          unit_n  = 2'd0;
        end
      end
      CHAR_GAP, WORD_GAP: begin
        if (st_end) begin
          state_n = IDLE;
          cyc_n   = '0;
          unit_n  = 2'd0;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    key_n = (state_n == MARK);
  end

  // state, counters, code and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cyc     <= '0;
      unit    <= '0;
      code_q  <= '0;
      len_q   <= '0;
      key_out <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      cyc     <= cyc_n;
      unit    <= unit_n;
      code_q  <= code_n;
      len_q   <= len_n;
      key_out <= key_n;
      done    <= done_n;
      err     <= err_n;
    end
  end

endmodule
